// File: rtl/shift_pkg.sv
// Shared definitions for the PISO serializer: FSM encoding, counter sizing
// and the default idle level of the serial line.
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  // Counter must hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Remaining-bits counter for one serial frame: loads WIDTH, counts down on
// each consumed bit and flags the final bit of the frame.
module shift_bit_counter
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(WIDTH);
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, per-word bit
// order, serial-side stall and frame status (serial_valid/busy/done).
module piso_serializer
  import shift_pkg::*;
#(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             dir;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             in_shift;
  logic             consume;
  logic             accept;

  assign in_shift = (state == ST_SHIFT);
  assign consume  = in_shift & shift_en;
  // Ready on the last consumed bit too, so frames can run back-to-back.
  assign in_ready = (state == ST_IDLE) | (consume & last);
  assign accept   = in_valid & in_ready;

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .dec  (consume),
    .cnt  (cnt),
    .last (last)
  );

  // NOTE: the datapath registers are reset along with the FSM so the line
  // is quiet and deterministic straight out of reset; a mid-frame reset
  // discards the partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      shreg <= '0;
      dir   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= consume & last;
      if (accept) begin
        shreg <= in_data;
        dir   <= in_msb_first;
        state <= ST_SHIFT;
      end else if (consume) begin
        shreg <= dir ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        if (last) begin
          state <= ST_IDLE;
        end
      end
    end
  end

  assign serial_out   = in_shift ? (dir ? shreg[WIDTH-1] : shreg[0]) : IDLE_LEVEL;
  assign serial_valid = in_shift;
  assign busy         = in_shift;

  // A frame in progress always has at least one bit left to send.
  a_cnt_nonzero : assert property (@(posedge clk) disable iff (rst) in_shift |-> (cnt != '0));

endmodule
